// File: rtl/cfm_reset_ctrl.sv
// -----------------------------------------------------------------------------
// cfm_reset_ctrl
// Clock/reset sequencer for the CFM board top level. Synchronizes and filters
// PLL lock, holds the core in reset for a fixed settle window and re-enters
// reset on lock loss, on a software request, or on watchdog timeout. The
// cause of the most recent reset is latched in reset_cause.
//
// Optional feature: define CFM_RESET_WDT_EN to build the watchdog. Without
// it, wdt_kick is ignored and reset_cause[3] is constant 0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cfm_reset_ctrl #(
    parameter int LOCK_FILTER = 4,
    parameter int HOLD_CYCLES = 128,
    parameter int WDT_WIDTH   = 20
) (
    input  logic       clk_core,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       sw_reset_req,
    input  logic       wdt_kick,
    output logic       core_reset,
    output logic       pll_stable,
    output logic [1:0] state,
    output logic [3:0] reset_cause
);

    // State encoding is visible on the state output
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    localparam logic [3:0] CAUSE_POR  = 4'b0001;
    localparam logic [3:0] CAUSE_LOCK = 4'b0010;
    localparam logic [3:0] CAUSE_SW   = 4'b0100;
    localparam logic [3:0] CAUSE_WDT  = 4'b1000;

    localparam logic [3:0]  LOCK_MAX  = 4'(LOCK_FILTER);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    // Registers
    logic        r_sync_meta;
    logic        r_lock_s;
    logic [3:0]  r_lock_cnt;
    logic [15:0] r_hold_cnt;
    logic [1:0]  r_state;
    logic        r_core_reset;
    logic        r_pll_stable;
    logic [3:0]  r_reset_cause;

    // Combinational next values
    logic [3:0]  w_lock_cnt_nxt;
    logic [15:0] w_hold_cnt_nxt;
    logic [1:0]  w_state_nxt;
    logic        w_core_reset_nxt;
    logic        w_pll_stable_nxt;
    logic [3:0]  w_reset_cause_nxt;
    logic        w_stable;
    logic        w_hold_done;
    logic        w_wdt_timeout;

    // -------------------------------------------------------------------------
    // Lock input conditioning
    // -------------------------------------------------------------------------

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk_core
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_sync_meta <= pll_locked;
            r_lock_s    <= r_sync_meta;
        end
    end

    // Lock filter: count consecutive lock-high cycles, saturating at the filter
    // length; a value above the limit is pulled back to the limit
    always_comb begin
        w_lock_cnt_nxt = r_lock_cnt;
        if (!r_lock_s) begin
            w_lock_cnt_nxt = 4'd0;
        end else if (r_lock_cnt >= LOCK_MAX) begin
            w_lock_cnt_nxt = LOCK_MAX;
        end else begin
            w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end
    end

    // Lock filter counter register
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_lock_cnt <= 4'd0;
        end else begin
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign w_stable = (r_lock_cnt == LOCK_MAX);

    // -------------------------------------------------------------------------
    // Watchdog
    // -------------------------------------------------------------------------
`ifdef CFM_RESET_WDT_EN
    logic [WDT_WIDTH-1:0] r_wdt_cnt;

    // Watchdog counter: runs only while the core is released, restarted by kick
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_wdt_cnt <= {WDT_WIDTH{1'b0}};
        end else if ((r_state != ST_RUN) || wdt_kick) begin
            r_wdt_cnt <= {WDT_WIDTH{1'b0}};
        end else begin
            r_wdt_cnt <= r_wdt_cnt + {{(WDT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // A kick in the same cycle as the all-ones count suppresses the timeout
    assign w_wdt_timeout = (r_state == ST_RUN) && !wdt_kick && (&r_wdt_cnt);
`else
    // Watchdog not built: kick input is deliberately left without effect
    logic [WDT_WIDTH-1:0] w_unused_wdt;
    assign w_unused_wdt  = {WDT_WIDTH{wdt_kick}};
    assign w_wdt_timeout = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_hold_done = (r_hold_cnt >= HOLD_LAST);

    // FSM next-state logic; RUN exits are prioritised lock loss, watchdog, software
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_stable) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end
            ST_HOLD: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_hold_done) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (w_wdt_timeout) begin
                    w_state_nxt = ST_HOLD;
                end else if (sw_reset_req) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_LOCK;
            end
        endcase
    end

    // FSM output logic: reset follows the next state, cause updates on RUN exits
    always_comb begin
        w_core_reset_nxt  = (w_state_nxt != ST_RUN);
        w_pll_stable_nxt  = w_stable;
        w_reset_cause_nxt = r_reset_cause;
        if (r_state == ST_RUN) begin
            if (!r_lock_s) begin
                w_reset_cause_nxt = CAUSE_LOCK;
            end else if (w_wdt_timeout) begin
                w_reset_cause_nxt = CAUSE_WDT;
            end else if (sw_reset_req) begin
                w_reset_cause_nxt = CAUSE_SW;
            end else begin
                w_reset_cause_nxt = r_reset_cause;
            end
        end else begin
            w_reset_cause_nxt = r_reset_cause;
        end
    end

    // Hold window counter: counts only while staying in HOLD, zero on entry
    always_comb begin
        w_hold_cnt_nxt = 16'd0;
        if ((r_state == ST_HOLD) && (w_state_nxt == ST_HOLD)) begin
            w_hold_cnt_nxt = r_hold_cnt + 16'd1;
        end else begin
            w_hold_cnt_nxt = 16'd0;
        end
    end

    // Hold counter register
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_hold_cnt <= 16'd0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Registered outputs, updated on the same edge as the state
    always_ff @(posedge clk_core or posedge reset) begin
        if (reset) begin
            r_core_reset  <= 1'b1;
            r_pll_stable  <= 1'b0;
            r_reset_cause <= CAUSE_POR;
        end else begin
            r_core_reset  <= w_core_reset_nxt;
            r_pll_stable  <= w_pll_stable_nxt;
            r_reset_cause <= w_reset_cause_nxt;
        end
    end

    assign core_reset  = r_core_reset;
    assign pll_stable  = r_pll_stable;
    assign state       = r_state;
    assign reset_cause = r_reset_cause;

endmodule

// File: tb/tb_cfm_reset_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cfm_reset_ctrl. Directed steps followed by a random
// phase, every cycle compared against a behavioural model that tracks lock
// streaks, release deadlines and the latched cause.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cfm_reset_ctrl;

    localparam int LF    = 4;
    localparam int HC    = 128;
    localparam int WDT_W = 8;

`ifdef CFM_RESET_WDT_EN
    localparam bit WDT_ON = 1'b1;
    localparam int COMB_N = 253;
`else
    localparam bit WDT_ON = 1'b0;
    localparam int COMB_N = 20;
`endif

    localparam int M_WAIT = 0;
    localparam int M_HOLD = 1;
    localparam int M_RUN  = 2;

    logic       clk_core;
    logic       reset;
    logic       pll_locked;
    logic       sw_reset_req;
    logic       wdt_kick;
    logic       core_reset;
    logic       pll_stable;
    logic [1:0] state;
    logic [3:0] reset_cause;

    int n_checks;
    int n_pass;
    int n_fail;

    // Behavioural model
    logic       m_sync1;
    logic       m_lock_s;
    logic       m_stable_q;
    int         m_streak;
    int         m_mode;
    int         m_release;
    int         m_idle;
    int         m_edge;
    logic [3:0] m_cause;

    cfm_reset_ctrl #(
        .LOCK_FILTER (LF),
        .HOLD_CYCLES (HC),
        .WDT_WIDTH   (WDT_W)
    ) dut (
        .clk_core     (clk_core),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .wdt_kick     (wdt_kick),
        .core_reset   (core_reset),
        .pll_stable   (pll_stable),
        .state        (state),
        .reset_cause  (reset_cause)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, m_edge);
        end
    endtask

    task automatic model_reset();
        m_sync1    = 1'b0;
        m_lock_s   = 1'b0;
        m_stable_q = 1'b0;
        m_streak   = 0;
        m_mode     = M_WAIT;
        m_release  = 0;
        m_idle     = 0;
        m_edge     = 0;
        m_cause    = 4'b0001;
    endtask

    // One clock edge of the reference: inputs are the values present before the edge
    task automatic model_edge(input logic pl, input logic sw, input logic kk);
        bit stable_pre;
        bit timeout_pre;
        m_edge++;
        stable_pre  = (m_streak >= LF);
        timeout_pre = WDT_ON && (m_mode == M_RUN) && !kk && (m_idle == (1 << WDT_W) - 1);
        m_idle      = ((m_mode != M_RUN) || kk) ? 0 : m_idle + 1;
        case (m_mode)
            M_WAIT: begin
                if (stable_pre) begin
                    m_mode    = M_HOLD;
                    m_release = m_edge + HC;
                end
            end
            M_HOLD: begin
                if (!m_lock_s) m_mode = M_WAIT;
                else if (m_edge == m_release) m_mode = M_RUN;
            end
            default: begin
                if (!m_lock_s) begin
                    m_mode  = M_WAIT;
                    m_cause = 4'b0010;
                end else if (timeout_pre) begin
                    m_mode    = M_HOLD;
                    m_release = m_edge + HC;
                    m_cause   = 4'b1000;
                end else if (sw) begin
                    m_mode    = M_HOLD;
                    m_release = m_edge + HC;
                    m_cause   = 4'b0100;
                end
            end
        endcase
        m_stable_q = stable_pre;
        m_streak   = m_lock_s ? m_streak + 1 : 0;
        m_lock_s   = m_sync1;
        m_sync1    = pl;
    endtask

    // Advance one clock, update the model and compare all outputs 1 ns later
    task automatic step();
        logic pl;
        logic sw;
        logic kk;
        pl = pll_locked;
        sw = sw_reset_req;
        kk = wdt_kick;
        @(posedge clk_core);
        model_edge(pl, sw, kk);
        #1;
        check("core_reset",  {3'b000, core_reset}, {3'b000, (m_mode != M_RUN)});
        check("pll_stable",  {3'b000, pll_stable}, {3'b000, m_stable_q});
        check("state",       {2'b00, state},       4'(m_mode));
        check("reset_cause", reset_cause,          m_cause);
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag);
        int n;
        n = 0;
        while ((state !== tgt) && (n < budget)) begin
            step();
            n++;
        end
        check(tag, {2'b00, state}, {2'b00, tgt});
    endtask

    initial begin
        int n;
        int lk_down;
        int sw_left;
        n_checks     = 0;
        n_pass       = 0;
        n_fail       = 0;
        reset        = 1'b1;
        pll_locked   = 1'b1;
        sw_reset_req = 1'b0;
        wdt_kick     = 1'b0;
        model_reset();

        // Reset values
        #3;
        check("rst_core_reset", {3'b000, core_reset}, 4'b0001);
        check("rst_pll_stable", {3'b000, pll_stable}, 4'b0000);
        check("rst_state",      {2'b00, state},       4'b0000);
        check("rst_cause",      reset_cause,          4'b0001);
        @(posedge clk_core);
        @(posedge clk_core);
        #1 reset = 1'b0;

        // Power-on release with steady lock: core_reset falls at edge 135
        for (int i = 1; i <= 135; i++) begin
            step();
            if (i == 134) check("por_edge134", {3'b000, core_reset}, 4'b0001);
            if (i == 135) check("por_edge135", {3'b000, core_reset}, 4'b0000);
        end
        check("por_cause", reset_cause, 4'b0001);

        // Software reset pulse: exactly HOLD_CYCLES cycles of core reset
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("sw_state_hold", {2'b00, state}, 4'b0001);
        check("sw_cause", reset_cause, 4'b0100);
        n = 1;
        while ((core_reset === 1'b1) && (n < 300)) begin
            step();
            if (core_reset === 1'b1) n++;
        end
        check_int("sw_hold_len", n, HC);
        check("sw_state_run", {2'b00, state}, 4'b0010);

        // Lock loss for 10 cycles while running
        pll_locked = 1'b0;
        step();
        step();
        check("lockloss_edge2", {3'b000, core_reset}, 4'b0000);
        step();
        check("lockloss_edge3", {3'b000, core_reset}, 4'b0001);
        check("lockloss_cause", reset_cause, 4'b0010);
        repeat (7) step();
        pll_locked = 1'b1;
        n = 0;
        while ((core_reset !== 1'b0) && (n < 400)) begin
            step();
            n++;
        end
        check_int("relock_release_len", n, 3 + LF + HC);

`ifdef CFM_RESET_WDT_EN
        // Watchdog timeout without kicks, then periodic kicks keep RUN
        wdt_kick = 1'b0;
        n = 0;
        while ((state === 2'd2) && (n < 400)) begin
            step();
            n++;
        end
        check_int("wdt_run_len", n, 1 << WDT_W);
        check("wdt_cause", reset_cause, 4'b1000);
        wait_state(2'd2, 300, "wdt_rerun");
        for (int i = 0; i < 600; i++) begin
            wdt_kick = ((i % 200) == 199);
            step();
        end
        wdt_kick = 1'b0;
        check("wdt_kicked_run", {2'b00, state}, 4'b0010);
`endif

        // Lock loss, software request (and watchdog timeout) on the same edge
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        wait_state(2'd2, 300, "comb_enter_run");
        for (int i = 0; i < COMB_N; i++) step();
        pll_locked = 1'b0;
        step();
        step();
        sw_reset_req = 1'b1;
        step();
        sw_reset_req = 1'b0;
        check("comb_state", {2'b00, state}, 4'b0000);
        check("comb_cause", reset_cause, 4'b0010);

        // Async reset during HOLD
        pll_locked = 1'b1;
        wait_state(2'd1, 60, "relock_hold");
        repeat (5) step();
        check("hold_cause_kept", reset_cause, 4'b0010);
        #2 reset = 1'b1;
        #1;
        check("areset_state", {2'b00, state}, 4'b0000);
        check("areset_core_reset", {3'b000, core_reset}, 4'b0001);
        check("areset_pll_stable", {3'b000, pll_stable}, 4'b0000);
        check("areset_cause", reset_cause, 4'b0001);
        model_reset();
        @(posedge clk_core);
        @(posedge clk_core);
        #1 reset = 1'b0;

        // Lock toggling every 3 cycles never becomes stable
        for (int i = 0; i < 60; i++) begin
            pll_locked = (((i / 3) % 2) == 0);
            step();
        end
        check("glitch_state", {2'b00, state}, 4'b0000);
        check("glitch_core_reset", {3'b000, core_reset}, 4'b0001);

        // Held software request retriggers on RUN re-entry
        pll_locked = 1'b1;
        wait_state(2'd2, 300, "retrig_run");
        sw_reset_req = 1'b1;
        step();
        wait_state(2'd2, 300, "retrig_rerun");
        step();
        check("retrig_hold", {2'b00, state}, 4'b0001);
        sw_reset_req = 1'b0;
        wait_state(2'd2, 300, "retrig_end");

        // Random phase against the model
        lk_down = 0;
        sw_left = 0;
        for (int i = 0; i < 6000; i++) begin
            if ((lk_down == 0) && ($urandom_range(399, 0) == 0)) lk_down = int'($urandom_range(12, 1));
            pll_locked = (lk_down == 0);
            if (lk_down > 0) lk_down--;
            if ((sw_left == 0) && ($urandom_range(249, 0) == 0)) sw_left = int'($urandom_range(3, 1));
            sw_reset_req = (sw_left != 0);
            if (sw_left > 0) sw_left--;
            wdt_kick = ($urandom_range(179, 0) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
